// File: rtl/merge_run_scheduler.sv
// Time-shares one 2-input merger across NUM_PAIRS leaf FIFO pairs. Each grant lasts
// one sorted run: it ends once a zero-key terminator has been read from both sides.
module merge_run_scheduler #(
  parameter int DATA_WIDTH   = 256,
  parameter int KEY_WIDTH    = 32,
  parameter int NUM_PAIRS    = 4,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_PAIRS*DATA_WIDTH-1:0] i_a_data,
  input  logic [NUM_PAIRS-1:0]            i_a_empty,
  input  logic [NUM_PAIRS*DATA_WIDTH-1:0] i_b_data,
  input  logic [NUM_PAIRS-1:0]            i_b_empty,
  output logic [NUM_PAIRS-1:0]            o_a_read,
  output logic [NUM_PAIRS-1:0]            o_b_read,
  output logic [DATA_WIDTH-1:0]           o_fifo_1,
  output logic                            o_fifo_1_empty,
  output logic [DATA_WIDTH-1:0]           o_fifo_2,
  output logic                            o_fifo_2_empty,
  input  logic                            i_fifo_1_read,
  input  logic                            i_fifo_2_read,
  output logic [$clog2(NUM_PAIRS)-1:0]    o_grant_id,
  output logic                            o_busy,
  output logic                            o_run_done
);

  localparam int GW = $clog2(NUM_PAIRS);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [GW-1:0]         grant_id, rr_ptr, pick, idx;
  logic                  pick_hit;
  logic                  a_done, b_done;
  logic [CW-1:0]         drain_cnt;
  logic                  busy, run_done;
  logic [NUM_PAIRS-1:0]  cand;
  logic [DATA_WIDTH-1:0] a_slice [NUM_PAIRS];
  logic [DATA_WIDTH-1:0] b_slice [NUM_PAIRS];
  logic [DATA_WIDTH-1:0] a_head, b_head;
  logic                  a_avail, b_avail, a_take, b_take, a_term, b_term, run_end;

  always_comb begin
    for (int unsigned p = 0; p < NUM_PAIRS; p++) begin
      a_slice[p] = i_a_data[p*DATA_WIDTH +: DATA_WIDTH];
      b_slice[p] = i_b_data[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign a_head  = a_slice[grant_id];
  assign b_head  = b_slice[grant_id];
  assign cand    = ~i_a_empty & ~i_b_empty;

  assign a_avail = (state == RUN) && !i_a_empty[grant_id] && !a_done;
  assign b_avail = (state == RUN) && !i_b_empty[grant_id] && !b_done;
  assign a_take  = i_fifo_1_read && a_avail;
  assign b_take  = i_fifo_2_read && b_avail;
  assign a_term  = a_take && (a_head[KEY_WIDTH-1:0] == '0);
  assign b_term  = b_take && (b_head[KEY_WIDTH-1:0] == '0);
  assign run_end = (a_done || a_term) && (b_done || b_term);

  // Round-robin scan starting just after the last grant; wraps back to rr_ptr itself last.
  always_comb begin
    pick     = '0;
    pick_hit = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_PAIRS; i++) begin
      idx = rr_ptr + GW'(i + 1);
      if (!pick_hit && cand[idx]) begin
        pick     = idx;
        pick_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_hit) state_nxt = RUN;
      RUN:     if (run_end) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_fifo_1_empty     = !a_avail;
    o_fifo_2_empty     = !b_avail;
    o_a_read           = '0;
    o_b_read           = '0;
    o_a_read[grant_id] = a_take;
    o_b_read[grant_id] = b_take;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant_id  <= '0;
      rr_ptr    <= '1;
      a_done    <= 1'b0;
      b_done    <= 1'b0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      run_done  <= 1'b0;
    end else begin
      run_done <= 1'b0;
      case (state)
        IDLE: if (pick_hit) begin
          grant_id <= pick;
          rr_ptr   <= pick;
          a_done   <= 1'b0;
          b_done   <= 1'b0;
          busy     <= 1'b1;
        end
        RUN: begin
          if (a_term)  a_done    <= 1'b1;
          if (b_term)  b_done    <= 1'b1;
          if (run_end) drain_cnt <= CW'(DRAIN_CYCLES - 1);
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            run_done <= 1'b1;
            busy     <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_fifo_1   = a_head;
  assign o_fifo_2   = b_head;
  assign o_grant_id = grant_id;
  assign o_busy     = busy;
  assign o_run_done = run_done;

endmodule

// File: tb/tb_merge_run_scheduler.sv
// Scoreboard bench: leaf FIFOs and a random merger are modelled here; expected run order and
// tuple streams come from a queue-level round-robin model built when the FIFOs are loaded.
module tb_merge_run_scheduler;

  localparam int DW = 256;
  localparam int KW = 32;
  localparam int NP = 4;
  localparam int DC = 16;
  localparam int GW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP*DW-1:0] a_data = '0, b_data = '0;
  logic [NP-1:0]    a_empty = '1, b_empty = '1;
  logic [NP-1:0]    a_rd, b_rd;
  logic [DW-1:0]    f1, f2;
  logic             f1_empty, f2_empty;
  logic             f1_rd = 1'b0, f2_rd = 1'b0;
  logic [GW-1:0]    grant;
  logic             busy, run_done;

  merge_run_scheduler #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .NUM_PAIRS(NP), .DRAIN_CYCLES(DC)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_data(a_data), .i_a_empty(a_empty), .i_b_data(b_data), .i_b_empty(b_empty),
    .o_a_read(a_rd), .o_b_read(b_rd),
    .o_fifo_1(f1), .o_fifo_1_empty(f1_empty), .o_fifo_2(f2), .o_fifo_2_empty(f2_empty),
    .i_fifo_1_read(f1_rd), .i_fifo_2_read(f2_rd),
    .o_grant_id(grant), .o_busy(busy), .o_run_done(run_done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] qa [NP][$];
  logic [DW-1:0] qb [NP][$];
  logic [DW-1:0] exp_a [$];
  logic [DW-1:0] exp_b [$];
  int            exp_g [$];
  int            checks = 0, errors = 0;
  int            rd_pct = 100;
  bit            hide_en = 1'b0;
  int            hide_cnt = 0;
  bit            hide_side = 1'b0;
  logic [NP-1:0] pop_a = '0, pop_b = '0;
  int            cyc = 0, term_cyc = 0;
  bit            a_fin = 1'b0, b_fin = 1'b0, busy_next = 1'b0;
  int            rda_cnt [NP];
  int            rdb_cnt [NP];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [KW-1:0] key);
    logic [DW-1:0] t;
    for (int i = 0; i < DW / 32; i++) t[i*32 +: 32] = $urandom;
    t[KW-1:0] = key;
    return t;
  endfunction

  task automatic put(input int p, input bit side_b, input logic [KW-1:0] key);
    if (side_b) qb[p].push_back(mk(key));
    else        qa[p].push_back(mk(key));
  endtask

  task automatic load_rand(input int p);
    int na, nb;
    na = $urandom_range(1, 6);
    nb = $urandom_range(1, 6);
    for (int i = 1; i < na; i++) put(p, 1'b0, $urandom | 32'h1);
    put(p, 1'b0, '0);
    for (int i = 1; i < nb; i++) put(p, 1'b1, $urandom | 32'h1);
    put(p, 1'b1, '0);
  endtask

  // Round-robin over whole runs: next pair after the last grant holding data on both sides.
  task automatic build_model();
    logic [DW-1:0] ca [NP][$];
    logic [DW-1:0] cb [NP][$];
    logic [DW-1:0] t;
    int ptr, found;
    for (int p = 0; p < NP; p++) begin
      ca[p] = qa[p];
      cb[p] = qb[p];
    end
    ptr = NP - 1;
    while (1) begin
      found = -1;
      for (int k = 1; k <= NP; k++)
        if (found < 0 && ca[(ptr + k) % NP].size() > 0 && cb[(ptr + k) % NP].size() > 0)
          found = (ptr + k) % NP;
      if (found < 0) break;
      ptr = found;
      exp_g.push_back(found);
      do begin t = ca[found].pop_front(); exp_a.push_back(t); end while (t[KW-1:0] != '0);
      do begin t = cb[found].pop_front(); exp_b.push_back(t); end while (t[KW-1:0] != '0);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_a_read", a_rd, '0);
    chk("rst_b_read", b_rd, '0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_run_done", run_done, 0);
    chk("rst_f1_empty", f1_empty, 1);
    chk("rst_f2_empty", f2_empty, 1);
    repeat (2) @(posedge clk);
    for (int p = 0; p < NP; p++) begin
      qa[p].delete();
      qb[p].delete();
      rda_cnt[p] = 0;
      rdb_cnt[p] = 0;
    end
    exp_a.delete();
    exp_b.delete();
    exp_g.delete();
  endtask

  task automatic release_rst();
    build_model();
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    if (exp_g.size() > 0) begin
      chk("grant_latency_busy", busy, 1);
      chk("first_grant_id", grant, exp_g[0]);
    end
  endtask

  task automatic wait_phase();
    for (int i = 0; i < 4000 && exp_g.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_g.size() > 0) begin
      errors++;
      $display("FAIL timeout: %0d runs outstanding, expected 0", exp_g.size());
    end
    repeat (DC + 4) @(negedge clk);
    chk("leftover_exp_a", exp_a.size(), 0);
    chk("leftover_exp_b", exp_b.size(), 0);
    for (int p = 0; p < NP; p++) begin
      chk("fifo_a_drained", qa[p].size(), 0);
      chk("fifo_b_drained", qb[p].size(), 0);
    end
  endtask

  // Leaf FIFOs and merger read strobes, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (pop_a[p] && qa[p].size() > 0) qa[p].delete(0);
        if (pop_b[p] && qb[p].size() > 0) qb[p].delete(0);
      end
      if (!busy) hide_cnt = 0;
      else if (hide_cnt > 0) hide_cnt--;
      else if (hide_en && $urandom_range(0, 15) == 0) begin
        hide_cnt  = 10;
        hide_side = 1'($urandom_range(0, 1));
      end
      f1_rd = ($urandom_range(0, 99) < rd_pct);
      f2_rd = ($urandom_range(0, 99) < rd_pct);
      for (int p = 0; p < NP; p++) begin
        a_data[p*DW +: DW] = (qa[p].size() > 0) ? qa[p][0] : '0;
        b_data[p*DW +: DW] = (qb[p].size() > 0) ? qb[p][0] : '0;
        a_empty[p] = (qa[p].size() == 0) || (hide_cnt > 0 && !hide_side);
        b_empty[p] = (qb[p].size() == 0) || (hide_cnt > 0 && hide_side);
      end
    end
  end

  // Monitor: compares whatever the merger accepts against the scoreboard queues.
  initial begin
    logic [DW-1:0] t;
    logic [NP-1:0] ea, eb;
    bit acc1, acc2, a_t, b_t;
    int g;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pop_a = '0; pop_b = '0;
        a_fin = 1'b0; b_fin = 1'b0; busy_next = 1'b0;
      end else begin
        pop_a = a_rd;
        pop_b = b_rd;
        for (int p = 0; p < NP; p++) begin
          rda_cnt[p] += int'(a_rd[p]);
          rdb_cnt[p] += int'(b_rd[p]);
        end
        if (busy_next) begin
          busy_next = 1'b0;
          chk("regrant_busy", busy, 1);
          if (exp_g.size() > 0) chk("regrant_id", grant, exp_g[0]);
        end
        g    = (exp_g.size() > 0) ? exp_g[0] : -1;
        acc1 = f1_rd && !f1_empty;
        acc2 = f2_rd && !f2_empty;
        ea = '0; eb = '0;
        if (g >= 0) begin
          ea[g] = acc1;
          eb[g] = acc2;
          if (a_fin || a_empty[g]) chk("f1_empty_hold", f1_empty, 1);
          if (b_fin || b_empty[g]) chk("f2_empty_hold", f2_empty, 1);
        end else begin
          chk("stray_accept_1", acc1, 0);
          chk("stray_accept_2", acc2, 0);
        end
        chk("a_read_strobe", a_rd, ea);
        chk("b_read_strobe", b_rd, eb);
        a_t = 1'b0; b_t = 1'b0;
        if (acc1 && exp_a.size() > 0) begin
          t = exp_a.pop_front();
          chk("f1_data", f1, t);
          a_t = (t[KW-1:0] == '0);
        end
        if (acc2 && exp_b.size() > 0) begin
          t = exp_b.pop_front();
          chk("f2_data", f2, t);
          b_t = (t[KW-1:0] == '0);
        end
        if (acc1 || acc2) chk("busy_in_run", busy, 1);
        if (a_t) a_fin = 1'b1;
        if (b_t) b_fin = 1'b1;
        if ((a_t || b_t) && a_fin && b_fin) term_cyc = cyc;
        if (run_done) begin
          if (exp_g.size() == 0) begin
            chk("spurious_run_done", run_done, 0);
          end else begin
            chk("done_grant_id", grant, exp_g[0]);
            chk("done_both_terms", {a_fin, b_fin}, 2'b11);
            chk("done_latency", cyc - term_cyc, DC + 1);
            chk("done_busy_low", busy, 0);
            void'(exp_g.pop_front());
            a_fin = 1'b0; b_fin = 1'b0;
            busy_next = (exp_g.size() > 0);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // Pair 2 alone: A={5,9,0}, B={3,0}, merger always reading.
    put(2, 1'b0, 5); put(2, 1'b0, 9); put(2, 1'b0, 0);
    put(2, 1'b1, 3); put(2, 1'b1, 0);
    rd_pct = 100; hide_en = 1'b0;
    release_rst();
    wait_phase();
    chk("pair2_a_reads", rda_cnt[2], 3);
    chk("pair2_b_reads", rdb_cnt[2], 2);

    // Terminator-only runs on every pair, pair 0 twice: order 0,1,2,3,0.
    do_reset();
    for (int p = 0; p < NP; p++) begin put(p, 1'b0, 0); put(p, 1'b1, 0); end
    put(0, 1'b0, 0); put(0, 1'b1, 0);
    release_rst();
    wait_phase();

    // A finishes first while B still streams.
    do_reset();
    put(0, 1'b0, 0);
    put(0, 1'b1, 4); put(0, 1'b1, 7); put(0, 1'b1, 0);
    put(3, 1'b0, 0); put(3, 1'b1, 0);
    rd_pct = 60;
    release_rst();
    wait_phase();

    // Long run on pair 0, then reset while the merger is reading.
    do_reset();
    for (int i = 0; i < 20; i++) begin put(0, 1'b0, i + 1); put(0, 1'b1, i + 1); end
    put(0, 1'b0, 0); put(0, 1'b1, 0);
    put(1, 1'b0, 0); put(1, 1'b1, 0);
    rd_pct = 100;
    release_rst();
    for (int i = 0; i < 100 && rda_cnt[0] < 3; i++) @(negedge clk);
    chk("pre_reset_a_read", a_rd[0], 1);

    // Random runs with stalls; the reset above restores pair 0 as first priority.
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      for (int p = 0; p < NP; p++)
        if (ph == 0 || $urandom_range(0, 2) != 0 || p == ph)
          repeat ($urandom_range(1, 3)) load_rand(p);
      rd_pct  = 50;
      hide_en = 1'b1;
      release_rst();
      wait_phase();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
